dac_source_sequencer: RTL and testbench
=======================================

Name: dac_source_sequencer

Overview:
Controls which of four 12-bit Avalon-ST sample streams drives the shared serial DAC. The streams are raw ADC, lowpass, bandpass and highpass. The block synchronizes and debounces the slide-switch select and changes source only on sample boundaries. On each change it inserts a muted (midscale) gap, then passes samples through. It sits between the filter outputs and dac_serial in the clk_20 domain and replaces the purely combinational switcher.

Parameters:
DATA_W, 12, sample width, offset binary.
DEBOUNCE_CYCLES, 200000, number of clk cycles select must be stable before it is accepted (10 ms at 20 MHz).
MUTE_SAMPLES, 64, number of midscale samples emitted after a source change; 0 means switch directly.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  sample-domain clock (clk_20)
reset  input  1  synchronous, active-high reset
select  input  2  raw switch select, asynchronous to clk
sink_data_0..3  input  DATA_W each  per-channel sample data
sink_valid_0..3  input  1 each  per-channel one-cycle sample strobe
sink_error_0..3  input  2 each  per-channel Avalon-ST error
source_data  output  DATA_W  sample to DAC
source_valid  output  1  one-cycle strobe to DAC
source_error  output  2  always 2'b00; errors are absorbed here
active_sel  output  2  channel currently routed
muting  output  1  high while in MUTE
err_count  output  ERR_CNT_W  saturating count of errored selected samples

Behaviour:
- Reset values: source_data=12'h800, source_valid=0, source_error=0, active_sel=0, muting=0, err_count=0, state=RUN. Sync flops, debounced select and last_good (=12'h800) are cleared as well. Reset applies on any cycle and abandons an in-progress mute or debounce.
- Select path: 2-flop synchronizer, then debouncer. The debouncer counter restarts whenever the synchronized value differs from the candidate. After DEBOUNCE_CYCLES consecutive equal cycles, the candidate becomes the debounced select and a one-cycle change pulse is raised if it differs from the previous debounced value.
- Only the selected channel's valid is observed. Non-selected valids and data are ignored.
- Latency: source_valid asserts exactly 1 clk after the accepted sink_valid. Data is registered with it and held until the next output.
- RUN state:
  - A selected valid with error==0 outputs sink data and updates last_good.
  - A selected valid with error!=0 outputs last_good and increments err_count.
- Change pulse (from any state): active_sel is updated the same cycle.
  - If MUTE_SAMPLES>0: go to MUTE, mute_cnt=MUTE_SAMPLES, muting=1.
  - Otherwise stay in RUN.
  - last_good is reset to 12'h800.
- MUTE state:
  - Each valid on the new active channel outputs 12'h800 and decrements mute_cnt. An errored sample still increments err_count.
  - When mute_cnt reaches 1 and a valid is accepted, the next state is RUN and muting=0; the following sample passes through.
  - A new change pulse during MUTE retargets active_sel and reloads mute_cnt=MUTE_SAMPLES.
- A change pulse and a selected valid in the same cycle: the valid belongs to the old channel and is output under the old rules. The state change takes effect from the next cycle.
- err_count saturates at all-ones and does not wrap.
- No backpressure: the DAC is always ready and sample rate is far below clk, so at most one output per valid.

Decomposition:
- Shared package, e.g. audio_stream_pkg: state enum {RUN, MUTE}, MIDSCALE = 12'h800, AST_ERR_W = 2, NUM_SRC = 4.
- One sub-module: select_debouncer (synchronizer plus stable-counter, parameterized width and DEBOUNCE_CYCLES), outputting the debounced value and change pulse.
- Channel mux, mute counter and error logic stay in the top.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, MUTE_SAMPLES=2.
- Reset, select=0, ch0 valids with data 12'h123 then 12'h456 -> source_valid 1 cycle after each; source_data 12'h123, 12'h456; active_sel=0.
- Switch select 0->2 held for 6 cycles, then ch2 valids with data 12'hA00 ×3 -> muting=1 and active_sel=2 after debounce. Outputs are 12'h800, 12'h800, then 12'hA00; muting falls after the 2nd mute sample.
- Select bounces 0->1->0 with each value held 2 cycles -> no change pulse; active_sel stays 0; ch1 valids produce no output.
- Selected ch0 valid with error=2'b01 after good sample 12'h300 -> output 12'h300, err_count 0->1. Force 300 errored samples -> err_count saturates at 255.
- Change 0->1 during MUTE after one mute sample, then 1->3 -> active_sel=3, mute_cnt reloaded; two midscale outputs on ch3 before passthrough.
- Assert reset mid-MUTE while select=3 -> all outputs return to reset values, active_sel=0. After 4+ stable cycles, change to 3 with a fresh 2-sample mute.

Source files
------------

// File: rtl/dac_source_sequencer_pkg.sv
// Shared types and constants for the DAC source sequencer and its select debouncer.
package dac_source_sequencer_pkg;

  localparam int unsigned NUM_SRC    = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned AST_ERR_W  = 2;
  localparam int unsigned DEF_DATA_W = 12;

  localparam logic [11:0] MIDSCALE = 12'h800;

  typedef enum logic {
    RUN  = 1'b0,
    MUTE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/dac_source_sequencer_select_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer for the slide-switch select.
// Raises a one-cycle change pulse when a newly accepted value differs from the last one.
module select_debouncer #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] value,
  output logic             change
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_c;

  // Candidate has matched the synchronized input for DEBOUNCE_CYCLES cycles.
  assign stable_c = (sync_q2 == cand_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      value   <= '0;
      change  <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      change  <= 1'b0;
      if (sync_q2 != cand_q) begin
        cand_q <= sync_q2;
        cnt_q  <= '0;
      end else if (stable_c) begin
        value  <= cand_q;
        change <= (cand_q != value);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_source_sequencer.sv
// Selects one of four Avalon-ST sample streams for the serial DAC, inserting a
// midscale gap on every source change and substituting last-good data for errored samples.
module dac_source_sequencer
  import dac_source_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned MUTE_SAMPLES    = 64,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     select,
  input  logic [DATA_W-1:0]    sink_data_0,
  input  logic [DATA_W-1:0]    sink_data_1,
  input  logic [DATA_W-1:0]    sink_data_2,
  input  logic [DATA_W-1:0]    sink_data_3,
  input  logic                 sink_valid_0,
  input  logic                 sink_valid_1,
  input  logic                 sink_valid_2,
  input  logic                 sink_valid_3,
  input  logic [AST_ERR_W-1:0] sink_error_0,
  input  logic [AST_ERR_W-1:0] sink_error_1,
  input  logic [AST_ERR_W-1:0] sink_error_2,
  input  logic [AST_ERR_W-1:0] sink_error_3,
  output logic [DATA_W-1:0]    source_data,
  output logic                 source_valid,
  output logic [AST_ERR_W-1:0] source_error,
  output logic [SEL_W-1:0]     active_sel,
  output logic                 muting,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned MUTE_W = (MUTE_SAMPLES < 2) ? 1 : $clog2(MUTE_SAMPLES + 1);
  localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_SAMPLES);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]    sink_data_a  [NUM_SRC];
  logic                 sink_valid_a [NUM_SRC];
  logic [AST_ERR_W-1:0] sink_error_a [NUM_SRC];

  assign sink_data_a[0]  = sink_data_0;
  assign sink_data_a[1]  = sink_data_1;
  assign sink_data_a[2]  = sink_data_2;
  assign sink_data_a[3]  = sink_data_3;
  assign sink_valid_a[0] = sink_valid_0;
  assign sink_valid_a[1] = sink_valid_1;
  assign sink_valid_a[2] = sink_valid_2;
  assign sink_valid_a[3] = sink_valid_3;
  assign sink_error_a[0] = sink_error_0;
  assign sink_error_a[1] = sink_error_1;
  assign sink_error_a[2] = sink_error_2;
  assign sink_error_a[3] = sink_error_3;

  logic [SEL_W-1:0] deb_sel;
  logic             deb_change;

  select_debouncer #(
    .WIDTH           (SEL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_select_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw    (select),
    .value  (deb_sel),
    .change (deb_change)
  );

  seq_state_e           state_q,     state_d;
  logic [MUTE_W-1:0]    mute_cnt_q,  mute_cnt_d;
  logic [DATA_W-1:0]    last_good_q, last_good_d;
  logic [DATA_W-1:0]    data_d;
  logic                 valid_d;
  logic [SEL_W-1:0]     active_sel_d;
  logic                 muting_d;
  logic [ERR_CNT_W-1:0] err_count_d;

  logic [DATA_W-1:0]    sel_data;
  logic                 sel_valid;
  logic [AST_ERR_W-1:0] sel_error;

  assign sel_data     = sink_data_a[active_sel];
  assign sel_valid    = sink_valid_a[active_sel];
  assign sel_error    = sink_error_a[active_sel];
  assign source_error = '0;

  // Sample handling under the current channel/state; a change pulse then overrides next-state.
  always_comb begin
    state_d      = state_q;
    mute_cnt_d   = mute_cnt_q;
    last_good_d  = last_good_q;
    data_d       = source_data;
    valid_d      = 1'b0;
    active_sel_d = active_sel;
    muting_d     = muting;
    err_count_d  = err_count;

    if (sel_valid) begin
      valid_d = 1'b1;
      if ((sel_error != '0) && (err_count != '1)) begin
        err_count_d = err_count + ERR_CNT_W'(1);
      end
      unique case (state_q)
        RUN: begin
          if (sel_error == '0) begin
            data_d      = sel_data;
            last_good_d = sel_data;
          end else begin
            data_d = last_good_q;
          end
        end
        MUTE: begin
          data_d = MID;
          if (mute_cnt_q <= MUTE_W'(1)) begin
            state_d  = RUN;
            muting_d = 1'b0;
          end else begin
            mute_cnt_d = mute_cnt_q - MUTE_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (deb_change) begin
      active_sel_d = deb_sel;
      last_good_d  = MID;
      if (MUTE_SAMPLES > 0) begin
        state_d    = MUTE;
        mute_cnt_d = MUTE_LOAD;
        muting_d   = 1'b1;
      end else begin
        state_d  = RUN;
        muting_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      mute_cnt_q   <= '0;
      last_good_q  <= MID;
      source_data  <= MID;
      source_valid <= 1'b0;
      active_sel   <= '0;
      muting       <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_d;
      mute_cnt_q   <= mute_cnt_d;
      last_good_q  <= last_good_d;
      source_data  <= data_d;
      source_valid <= valid_d;
      active_sel   <= active_sel_d;
      muting       <= muting_d;
      err_count    <= err_count_d;
    end
  end

endmodule

// File: tb/tb_dac_source_sequencer.sv
// Scoreboard bench for dac_source_sequencer with short debounce and a two-sample mute.
module tb_dac_source_sequencer;
  import dac_source_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  select;
  logic [11:0] sd [4];
  logic        sv [4];
  logic [1:0]  se [4];
  logic [11:0] source_data;
  logic        source_valid;
  logic [1:0]  source_error;
  logic [1:0]  active_sel;
  logic        muting;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [11:0] exp_q     [$];
  int          exp_cyc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_source_sequencer #(
    .DATA_W          (12),
    .DEBOUNCE_CYCLES (4),
    .MUTE_SAMPLES    (2),
    .ERR_CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .select       (select),
    .sink_data_0  (sd[0]),
    .sink_data_1  (sd[1]),
    .sink_data_2  (sd[2]),
    .sink_data_3  (sd[3]),
    .sink_valid_0 (sv[0]),
    .sink_valid_1 (sv[1]),
    .sink_valid_2 (sv[2]),
    .sink_valid_3 (sv[3]),
    .sink_error_0 (se[0]),
    .sink_error_1 (se[1]),
    .sink_error_2 (se[2]),
    .sink_error_3 (se[3]),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_error (source_error),
    .active_sel   (active_sel),
    .muting       (muting),
    .err_count    (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe on channel ch; an expected output is queued only when one should appear.
  task automatic pulse(input int ch, input logic [11:0] d, input logic [1:0] e,
                       input bit expect_out, input logic [11:0] exp_d);
    @(posedge clk);
    #1;
    sd[ch] = d;
    se[ch] = e;
    sv[ch] = 1'b1;
    if (expect_out) begin
      exp_q.push_back(exp_d);
      exp_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    sv[ch] = 1'b0;
    se[ch] = 2'b00;
  endtask

  task automatic check_reset_values();
    chk("rst_source_data", 32'(source_data), 32'(MIDSCALE));
    chk("rst_source_valid", 32'(source_valid), 32'h0);
    chk("rst_source_error", 32'(source_error), 32'h0);
    chk("rst_active_sel", 32'(active_sel), 32'h0);
    chk("rst_muting", 32'(muting), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
  endtask

  initial begin
    reset  = 1'b1;
    select = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sd[i] = 12'h000;
      sv[i] = 1'b0;
      se[i] = 2'b00;
    end

    // Scoreboard monitor: every output strobe must match the oldest queued expectation.
    fork
      forever begin
        @(negedge clk);
        if (source_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got data %0h while none expected (t=%0t)",
                     source_data, $time);
          end else begin
            logic [11:0] ed;
            int          ec;
            ed = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            chk("out_data", 32'(source_data), 32'(ed));
            chk("out_latency_cycle", 32'(cyc), 32'(ec));
            chk("out_error", 32'(source_error), 32'h0);
          end
        end
      end
    join_none

    // Reset and basic passthrough on channel 0.
    cycles(3);
    check_reset_values();
    reset = 1'b0;
    cycles(10);
    pulse(0, 12'h123, 2'b00, 1'b1, 12'h123);
    pulse(0, 12'h456, 2'b00, 1'b1, 12'h456);
    chk("sel0_active", 32'(active_sel), 32'h0);
    chk("sel0_muting", 32'(muting), 32'h0);

    // Switch to channel 2: two midscale samples, then passthrough.
    select = 2'd2;
    cycles(10);
    chk("sel2_active", 32'(active_sel), 32'h2);
    chk("sel2_muting", 32'(muting), 32'h1);
    pulse(0, 12'h0F0, 2'b00, 1'b0, 12'h000);
    pulse(2, 12'hA00, 2'b00, 1'b1, 12'h800);
    chk("sel2_muting_mid", 32'(muting), 32'h1);
    pulse(2, 12'hA00, 2'b00, 1'b1, 12'h800);
    chk("sel2_muting_done", 32'(muting), 32'h0);
    pulse(2, 12'hA00, 2'b00, 1'b1, 12'hA00);

    // Back to channel 0 and complete its mute.
    select = 2'd0;
    cycles(10);
    chk("back0_active", 32'(active_sel), 32'h0);
    pulse(0, 12'h111, 2'b00, 1'b1, 12'h800);
    pulse(0, 12'h222, 2'b00, 1'b1, 12'h800);
    chk("back0_muting_done", 32'(muting), 32'h0);

    // Bouncing select must not be accepted; channel 1 strobes are ignored.
    select = 2'd1;
    cycles(2);
    select = 2'd0;
    cycles(2);
    cycles(10);
    chk("bounce_active", 32'(active_sel), 32'h0);
    chk("bounce_muting", 32'(muting), 32'h0);
    pulse(1, 12'h999, 2'b00, 1'b0, 12'h000);

    // Errored samples replay last good data and saturate the error counter.
    pulse(0, 12'h300, 2'b00, 1'b1, 12'h300);
    pulse(0, 12'h777, 2'b01, 1'b1, 12'h300);
    chk("err_count_one", 32'(err_count), 32'h1);
    for (int i = 0; i < 299; i++) begin
      pulse(0, 12'h5A5, 2'b10, 1'b1, 12'h300);
    end
    chk("err_count_sat", 32'(err_count), 32'hFF);
    pulse(0, 12'h0AB, 2'b00, 1'b1, 12'h0AB);
    chk("err_count_hold", 32'(err_count), 32'hFF);

    // Retarget during mute: 0->1, one mute sample, then 1->3 reloads the mute count.
    select = 2'd1;
    cycles(10);
    chk("retarget1_active", 32'(active_sel), 32'h1);
    chk("retarget1_muting", 32'(muting), 32'h1);
    pulse(1, 12'h444, 2'b00, 1'b1, 12'h800);
    select = 2'd3;
    cycles(10);
    chk("retarget3_active", 32'(active_sel), 32'h3);
    chk("retarget3_muting", 32'(muting), 32'h1);
    pulse(3, 12'hBBB, 2'b00, 1'b1, 12'h800);
    pulse(3, 12'hBBB, 2'b00, 1'b1, 12'h800);
    chk("retarget3_muting_done", 32'(muting), 32'h0);
    pulse(3, 12'hCCC, 2'b00, 1'b1, 12'hCCC);

    // Reset in the middle of a mute with select moving to 3.
    select = 2'd0;
    cycles(10);
    pulse(0, 12'h666, 2'b00, 1'b1, 12'h800);
    chk("midmute_muting", 32'(muting), 32'h1);
    select = 2'd3;
    cycles(3);
    reset = 1'b1;
    cycles(2);
    check_reset_values();
    reset = 1'b0;
    cycles(1);
    chk("post_rst_active", 32'(active_sel), 32'h0);
    cycles(10);
    chk("post_rst_sel3_active", 32'(active_sel), 32'h3);
    chk("post_rst_sel3_muting", 32'(muting), 32'h1);
    pulse(3, 12'hDDD, 2'b00, 1'b1, 12'h800);
    pulse(3, 12'hDDD, 2'b00, 1'b1, 12'h800);
    pulse(3, 12'hDDD, 2'b00, 1'b1, 12'hDDD);
    chk("post_rst_err_count", 32'(err_count), 32'h0);

    cycles(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
